// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with an 8-entry TX FIFO.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   cs_n      chip select from the address decoder, active low
//   wen       bus write strobe, qualified by ~cs_n
//   addr      byte offset; addr[3:2] selects TXDATA / STATUS / CTRL / reserved
//   wdata     store data
//   rdata     read data, combinational from addr and current state (0 when deselected)
//   uart_txd  serial output, idle high, LSB first
//   tx_busy   high while the serializer is not idle
//   irq       irq_en & fifo empty & ~tx_busy
//
// Register map
//   0x0 TXDATA  W: push wdata[7:0]      R: 0
//   0x4 STATUS  R: [0]full [1]empty [2]tx_busy [3]overflow [7:4]count
//               W: a 1 in bit 3 clears overflow
//   0x8 CTRL    R/W: [0]tx_en [1]irq_en
//   0xC         reads 0, writes ignored
module uart_tx_mmio #(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        wen,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        irq
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_FW       = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] count;
        logic       overflow;
        logic       tx_busy;
        logic       empty;
        logic       full;
    } status_t;

    // Serializer state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               txd_d;
    logic               baud_done;

    // FIFO and control state
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_FW-1:0]  count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               tx_en_q, tx_en_d;
    logic               irq_en_q, irq_en_d;
    logic               irq_d;

    // Bus decode and FIFO handshake
    logic               wr_hit;
    logic               sel_data, sel_status, sel_ctrl;
    logic               push_req, push_ok, pop;
    logic               full, empty;
    status_t            status;

    logic               unused_bits;
    assign unused_bits = ^{wdata[31:8], addr[1:0]};

    // Address decode; a push that finds the FIFO full is still accepted if the FSM pops this cycle
    always_comb begin
        wr_hit     = ~cs_n & wen;
        sel_data   = (addr[3:2] == 2'd0);
        sel_status = (addr[3:2] == 2'd1);
        sel_ctrl   = (addr[3:2] == 2'd2);
        full       = (count_q == CNT_FW'(FIFO_DEPTH));
        empty      = (count_q == '0);
        pop        = (state_q == IDLE) & tx_en_q & ~empty;
        push_req   = wr_hit & sel_data;
        push_ok    = push_req & (~full | pop);
    end

    // FIFO occupancy, sticky overflow (set beats clear) and CTRL register
    always_comb begin
        count_d  = count_q;
        ovf_d    = ovf_q;
        tx_en_d  = tx_en_q;
        irq_en_d = irq_en_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_FW'(1);
            2'b01:   count_d = count_q - CNT_FW'(1);
            default: count_d = count_q;
        endcase
        if (wr_hit && sel_status && wdata[3]) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (wr_hit && sel_ctrl) begin
            tx_en_d  = wdata[0];
            irq_en_d = wdata[1];
        end
    end

    assign baud_done = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

    // Serializer next state; txd_d is the line level for the state being entered
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        txd_d   = uart_txd;
        case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                baud_d = '0;
                if (pop) begin
                    shreg_d = fifo_mem[rd_ptr_q];
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    txd_d   = shreg_q[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                txd_d = shreg_q[0];
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        txd_d   = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                txd_d = 1'b1;
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    // irq registered from next-state values so it tracks the registered flags exactly
    assign irq_d = irq_en_d & (count_d == '0) & (state_d == IDLE);

    // State registers; reset also wins over any bus write in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
            irq      <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            tx_en_q  <= 1'b1;
            irq_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            uart_txd <= txd_d;
            tx_busy  <= (state_d != IDLE);
            irq      <= irq_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            tx_en_q  <= tx_en_d;
            irq_en_q <= irq_en_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            fifo_mem[wr_ptr_q] <= wdata[7:0];
        end
    end

    // Read mux, valid in the same cycle as the access
    always_comb begin
        status.count    = 4'(count_q);
        status.overflow = ovf_q;
        status.tx_busy  = tx_busy;
        status.empty    = empty;
        status.full     = full;
        rdata = '0;
        if (!cs_n) begin
            case (addr[3:2])
                2'd1:    rdata = 32'(status);
                2'd2:    rdata = {30'd0, irq_en_q, tx_en_q};
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed bench for uart_tx_mmio with a byte scoreboard fed at push
// time and drained by a line monitor that decodes each frame from uart_txd.
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n;
    logic        wen;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        uart_txd;
    logic        tx_busy;
    logic        irq;

    uart_tx_mmio #(
        .CLOCK_FREQ (16),
        .BAUD_RATE  (1),
        .FIFO_DEPTH (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cs_n     (cs_n),
        .wen      (wen),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [7:0] sb [$];
    logic       mon_abort  = 1'b0;
    logic       mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Caller sits just after a negedge; the write lands on the next posedge
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        cs_n  = 1'b0;
        wen   = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        cs_n  = 1'b1;
        wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        cs_n = 1'b0;
        wen  = 1'b0;
        addr = a;
        #1;
        d    = rdata;
        cs_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] b, input logic accept);
        bus_write(4'h0, {24'h0, b});
        if (accept) sb.push_back(b);
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    // Waits for empty FIFO and idle serializer, bounded
    task automatic wait_drain(input string tag);
        logic [31:0] s;
        int n;
        n = 0;
        s = '0;
        do begin
            @(negedge clk);
            bus_read(4'h4, s);
            n++;
        end while (!(s[1] && !s[2]) && n < 3000);
        check(tag, s & 32'h6, 32'h2);
        check({tag, "_sb"}, 32'(sb.size()), 32'd0);
    endtask

    // Expected line level k cycles after the push edge of an isolated frame
    function automatic logic exp_txd(input logic [7:0] b, input int k);
        logic [7:0] v;
        v = b;
        if (k < 1)    return 1'b1;
        if (k <= 16)  return 1'b0;
        if (k <= 144) return v[3'((k - 17) / 16)];
        return 1'b1;
    endfunction

    // Line monitor: mid-bit sampling, compare against scoreboard at the stop bit
    always @(negedge clk) begin
        if (reset || mon_abort) begin
            mon_active = 1'b0;
            mon_abort  = 1'b0;
        end else if (!mon_active) begin
            if (uart_txd === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_byte   = 8'h00;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 8) begin
                check("start_bit", 32'(uart_txd), 32'd0);
            end else if (mon_cnt >= 24 && mon_cnt <= 136 && ((mon_cnt - 8) % 16) == 0) begin
                mon_byte[3'((mon_cnt - 24) / 16)] = uart_txd;
            end else if (mon_cnt == 152) begin
                check("stop_bit", 32'(uart_txd), 32'd1);
                check("frame_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("frame_byte", 32'(mon_byte), 32'(sb.pop_front()));
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        int k, first_low, busy_cnt, wave_err, second_start, lows;

        reset = 1'b1;
        cs_n  = 1'b1;
        wen   = 1'b0;
        addr  = 4'h4;
        wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        #1;
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata_desel", rdata, 32'd0);
        read_check("rst_status", 4'h4, 32'h02);
        read_check("rst_ctrl", 4'h8, 32'h01);
        @(negedge clk);

        // 1. Single byte 0x55: waveform and busy length
        push(8'h55, 1'b1);
        w = cyc;
        check("t1_pop_cycle_txd", 32'(uart_txd), 32'd1);
        check("t1_pop_cycle_busy", 32'(tx_busy), 32'd0);
        first_low = 0;
        busy_cnt  = 0;
        wave_err  = 0;
        for (int i = 0; i < 175; i++) begin
            @(negedge clk);
            k = int'(cyc - w);
            if (first_low == 0 && uart_txd == 1'b0) first_low = k;
            if (tx_busy) busy_cnt++;
            if (uart_txd !== exp_txd(8'h55, k)) wave_err++;
        end
        check("t1_first_low", 32'(first_low), 32'd1);
        check("t1_busy_cycles", 32'(busy_cnt), 32'd160);
        check("t1_wave_errors", 32'(wave_err), 32'd0);
        wait_drain("t1_drain");

        // 2. Back-to-back frames with a one-cycle idle gap
        push(8'hA5, 1'b1);
        w = cyc;
        push(8'h3C, 1'b1);
        second_start = 0;
        do begin
            @(negedge clk);
            k = int'(cyc - w);
            if (k == 20) read_check("t2_status_first_frame", 4'h4, 32'h14);
            if (k == 162) read_check("t2_status_after_pop2", 4'h4, 32'h06);
            if (k > 160 && second_start == 0 && uart_txd == 1'b0) second_start = k;
        end while (k < 330);
        check("t2_second_start", 32'(second_start), 32'd162);
        wait_drain("t2_drain");

        // 3. Fill with tx_en = 0, overflow, clear
        bus_write(4'h8, 32'h0);
        read_check("t3_ctrl_off", 4'h8, 32'h00);
        for (int i = 0; i < 9; i++) begin
            push(8'(8'hC1 + 8'(i * 13)), (i < 8));
        end
        read_check("t3_status_full_ovf", 4'h4, 32'h89);
        bus_write(4'h4, 32'hF7);
        read_check("t3_ovf_kept", 4'h4, 32'h89);
        bus_write(4'h4, 32'h8);
        read_check("t3_ovf_cleared", 4'h4, 32'h81);

        // 4. Enable, and push in the very cycle the FSM pops from a full FIFO
        bus_write(4'h8, 32'h1);
        push(8'h99, 1'b1);
        read_check("t4_status_push_pop", 4'h4, 32'h85);
        wait_drain("t34_drain");

        // 5. Reset during DATA bit 3, concurrent CTRL write must lose
        push(8'h0F, 1'b1);
        w = cyc;
        while (int'(cyc - w) < 70) @(negedge clk);
        check("t5_busy_before", 32'(tx_busy), 32'd1);
        reset     = 1'b1;
        mon_abort = 1'b1;
        cs_n      = 1'b0;
        wen       = 1'b1;
        addr      = 4'h8;
        wdata     = 32'h2;
        @(negedge clk);
        reset = 1'b0;
        cs_n  = 1'b1;
        wen   = 1'b0;
        sb.delete();
        #1;
        check("t5_txd", 32'(uart_txd), 32'd1);
        check("t5_busy", 32'(tx_busy), 32'd0);
        read_check("t5_status", 4'h4, 32'h02);
        read_check("t5_ctrl", 4'h8, 32'h01);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) lows++;
        end
        check("t5_no_residual", 32'(lows), 32'd0);

        // 6. irq behaviour and decode
        check("t6_irq_off", 32'(irq), 32'd0);
        bus_write(4'h8, 32'h3);
        check("t6_irq_on", 32'(irq), 32'd1);
        push(8'h81, 1'b1);
        check("t6_irq_drop", 32'(irq), 32'd0);
        cs_n  = 1'b1;
        wen   = 1'b1;
        addr  = 4'h0;
        wdata = 32'hEE;
        @(negedge clk);
        addr  = 4'h8;
        wdata = 32'h0;
        @(negedge clk);
        addr  = 4'h4;
        wdata = 32'h8;
        #1;
        check("t6_rdata_desel", rdata, 32'd0);
        wen = 1'b0;
        @(negedge clk);
        read_check("t6_txdata_reads0", 4'h0, 32'h0);
        bus_write(4'hC, 32'hFFFF_FFFF);
        read_check("t6_reserved_reads0", 4'hC, 32'h0);
        read_check("t6_ctrl_kept", 4'h8, 32'h03);
        wait_drain("t6_drain");
        check("t6_irq_back", 32'(irq), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
